// File: rtl/weighted_round_robin_dispatcher_if.sv
// rtl/weighted_round_robin_dispatcher_if.sv - input stream and fan-out bus of the weighted round-robin dispatcher
interface weighted_round_robin_dispatcher_if #(
  parameter int CLIENTS    = 8,
  parameter int DATA_WIDTH = 32
);
  logic                       in_valid;
  logic                       in_ready;
  logic [DATA_WIDTH-1:0]      in_data;
  logic [CLIENTS-1:0]         out_valid;
  logic [CLIENTS-1:0]         out_ready;
  logic [DATA_WIDTH-1:0]      out_data;
  logic [$clog2(CLIENTS)-1:0] out_dest;

  // producer side plus destination readies
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_dest
  );

  // dispatcher side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_dest
  );
endinterface

// File: rtl/weighted_round_robin_dispatcher.sv
// rtl/weighted_round_robin_dispatcher.sv - one-to-many weighted round-robin beat dispatcher (optional WRR_DISPATCH_CLIENT_MASK_EN adds client_en_i)
module weighted_round_robin_dispatcher #(
  parameter int CLIENTS    = 8,
  parameter int MAX_THRESH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [CLIENTS-1:0][$clog2(MAX_THRESH)-1:0]   max_thresh_i,
`ifdef WRR_DISPATCH_CLIENT_MASK_EN
  input  logic [CLIENTS-1:0]                           client_en_i,
`endif
  weighted_round_robin_dispatcher_if.slave             bus
);
  localparam int TW = $clog2(MAX_THRESH);
  localparam int CW = $clog2(MAX_THRESH + 1);
  localparam int DW = $clog2(CLIENTS);

  typedef enum logic [1:0] {IDLE, ARB, SEND} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DW-1:0]         dest_q;
  logic [DW-1:0]         last_ptr_q;
  logic [CW-1:0]         crd_cnt_q [CLIENTS];

  logic [CLIENTS-1:0]    eff_ready;
  logic [CLIENTS-1:0]    has_crd;
  logic [CLIENTS-1:0]    cand;
  logic                  replenish;
  logic [DW-1:0]         pick;
  logic                  capture;
  logic                  lock;
  logic                  in_ready;
  logic [CLIENTS-1:0]    out_valid;

`ifdef WRR_DISPATCH_CLIENT_MASK_EN
  assign eff_ready = bus.out_ready & client_en_i;
`else
  assign eff_ready = bus.out_ready;
`endif

  // a destination has credit while one more beat stays within its live weight
  always_comb begin
    has_crd = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      has_crd[i] = (({1'b0, crd_cnt_q[i]} + (CW+1)'(1)) <= (CW+1)'(max_thresh_i[i]));
    end
  end

  // a new round starts only when some ready destination exists but none has credit left
  assign replenish = ((eff_ready & has_crd) == '0) && (eff_ready != '0);
  assign cand      = replenish ? eff_ready : (eff_ready & has_crd);

  // rotating-priority search starting just after the last served destination
  always_comb begin
    logic          found;
    logic [DW-1:0] idx;
    found = 1'b0;
    idx   = '0;
    pick  = last_ptr_q;
    for (int k = 1; k <= CLIENTS; k++) begin
      idx = DW'((int'(last_ptr_q) + k) % CLIENTS);
      if (!found && cand[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state, handshakes and datapath enables
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = '0;
    capture   = 1'b0;
    lock      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          capture = 1'b1;
          state_d = ARB;
        end
      end
      ARB: begin
        if (eff_ready != '0) begin
          lock    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        out_valid = CLIENTS'(1) << dest_q;
        in_ready  = bus.out_ready[dest_q];
        if (bus.out_ready[dest_q]) begin
          if (bus.in_valid) begin
            capture = 1'b1;
            state_d = ARB;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // holding register, locked destination, pointer and credit counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      dest_q     <= '0;
      last_ptr_q <= DW'(CLIENTS - 1);
      for (int i = 0; i < CLIENTS; i++) begin
        crd_cnt_q[i] <= '0;
      end
    end else begin
      if (capture) begin
        data_q <= bus.in_data;
      end
      if (lock) begin
        dest_q     <= pick;
        last_ptr_q <= pick;
        for (int i = 0; i < CLIENTS; i++) begin
          if (replenish) begin
            crd_cnt_q[i] <= (DW'(i) == pick) ? CW'(1) : '0;
          end else if (DW'(i) == pick) begin
            crd_cnt_q[i] <= crd_cnt_q[i] + CW'(1);
          end
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = data_q;
  assign bus.out_dest  = dest_q;

endmodule

// File: tb/tb_weighted_round_robin_dispatcher.sv
// tb/tb_weighted_round_robin_dispatcher.sv - randomized bench for the weighted round-robin dispatcher against a round/share model
module tb_weighted_round_robin_dispatcher;
  localparam int C  = 4;
  localparam int MT = 8;
  localparam int TW = 3;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [C-1:0][TW-1:0] max_thresh;
`ifdef WRR_DISPATCH_CLIENT_MASK_EN
  logic [C-1:0]      client_en = '1;
`endif

  weighted_round_robin_dispatcher_if #(.CLIENTS(C), .DATA_WIDTH(DW)) bus ();

  weighted_round_robin_dispatcher #(.CLIENTS(C), .MAX_THRESH(MT), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .max_thresh_i (max_thresh),
`ifdef WRR_DISPATCH_CLIENT_MASK_EN
    .client_en_i  (client_en),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // transaction-level reference: holding slot, locked flag, per-round usage
  logic          m_full;
  logic          m_locked;
  logic [DW-1:0] m_data;
  int            m_dest;
  int            m_used [C];
  int            m_last;
  int            lock_log [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full   = 1'b0;
    m_locked = 1'b0;
    m_data   = '0;
    m_dest   = 0;
    m_last   = C - 1;
    for (int i = 0; i < C; i++) m_used[i] = 0;
    lock_log.delete();
  endtask

  // each ready destination may take "weight" beats per round; an empty round restarts
  task automatic model_pick(input logic [C-1:0] rdy, output int d);
    logic [C-1:0] elig;
    elig = '0;
    for (int i = 0; i < C; i++)
      if (rdy[i] && (m_used[i] < int'(max_thresh[i]))) elig[i] = 1'b1;
    if (elig == '0) begin
      for (int i = 0; i < C; i++) m_used[i] = 0;
      elig = rdy;
    end
    d = 0;
    for (int k = 1; k <= C; k++) begin
      int idx;
      idx = (m_last + k) % C;
      if (elig[idx]) begin
        d = idx;
        break;
      end
    end
    m_used[d]++;
    m_last = d;
  endtask

  // check outputs mid-cycle, advance the model across the coming edge
  task automatic step();
    int d;
    @(negedge clk);
    if (!m_full) begin
      chk("in_ready_empty", bus.in_ready, 1);
      chk("out_valid_empty", bus.out_valid, 0);
      if (bus.in_valid) begin
        m_full   = 1'b1;
        m_locked = 1'b0;
        m_data   = bus.in_data;
      end
    end else if (!m_locked) begin
      chk("in_ready_arb", bus.in_ready, 0);
      chk("out_valid_arb", bus.out_valid, 0);
      chk("out_data_arb", bus.out_data, m_data);
      if (bus.out_ready != '0) begin
        model_pick(bus.out_ready, d);
        m_dest   = d;
        m_locked = 1'b1;
        lock_log.push_back(d);
      end
    end else begin
      chk("out_valid_send", bus.out_valid, C'(1) << m_dest);
      chk("out_data_send", bus.out_data, m_data);
      chk("out_dest_send", bus.out_dest, m_dest);
      chk("in_ready_send", bus.in_ready, bus.out_ready[m_dest]);
      if (bus.out_ready[m_dest]) begin
        if (bus.in_valid) begin
          m_data   = bus.in_data;
          m_locked = 1'b0;
        end else begin
          m_full = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_locks(input int n, input int budget);
    int cyc;
    cyc = 0;
    while (lock_log.size() < n && cyc < budget) begin
      bus.in_data = $urandom;
      step();
      cyc++;
    end
    chk("lock_count", lock_log.size(), n);
  endtask

  function automatic int logged(input int i);
    return (i < lock_log.size()) ? lock_log[i] : -1;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_rr [8];
    int n0, n1, cyc;
    exp_rr = '{0, 1, 2, 3, 0, 1, 2, 3};

    // reset state
    for (int i = 0; i < C; i++) max_thresh[i] = 3'd1;
    do_reset();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_dest", bus.out_dest, 0);
    for (int i = 0; i < C; i++) chk("rst_crd", dut.crd_cnt_q[i], 0);
    repeat (3) step();

    // unit weights, all ready: plain rotation, fifth pick via replenish
    bus.out_ready = 4'hF;
    bus.in_valid  = 1'b1;
    run_locks(8, 100);
    for (int i = 0; i < 8; i++) chk("rr_seq", logged(i), exp_rr[i]);

    // weights 3:1 on two ready destinations
    do_reset();
    max_thresh[0] = 3'd3;
    max_thresh[1] = 3'd1;
    max_thresh[2] = 3'd0;
    max_thresh[3] = 3'd0;
    bus.out_ready = 4'b0011;
    bus.in_valid  = 1'b1;
    run_locks(16, 200);
    chk("wt_first0", logged(0), 0);
    chk("wt_first1", logged(1), 1);
    chk("wt_first2", logged(2), 0);
    chk("wt_first3", logged(3), 0);
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < lock_log.size(); i++) begin
      if (lock_log[i] == 0) n0++;
      if (lock_log[i] == 1) n1++;
    end
    chk("wt_share0", n0, 12);
    chk("wt_share1", n1, 4);

    // backpressure on a locked destination
    do_reset();
    for (int i = 0; i < C; i++) max_thresh[i] = 3'd1;
    bus.out_ready = 4'b0100;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hA5A5_1234;
    step();
    bus.in_valid = 1'b0;
    step();
    chk("bp_lock", logged(0), 2);
    bus.out_ready = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", bus.out_valid, 4'b0100);
      chk("bp_dest", bus.out_dest, 2);
      chk("bp_data", bus.out_data, 32'hA5A5_1234);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 4'b0100;
    step();
    chk("bp_release", bus.out_valid, 0);

    // handshake and accept in the same cycle
    bus.out_ready = 4'hF;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h1111_0001;
    step();
    step();
    chk("sim_locked", m_locked, 1);
    bus.in_data = 32'h2222_0002;
    step();
    chk("sim_valid_after", bus.out_valid, 0);
    chk("sim_in_ready_after", bus.in_ready, 0);
    chk("sim_new_data", bus.out_data, 32'h2222_0002);
    bus.in_valid = 1'b0;
    repeat (3) step();

    // randomized traffic with live weight changes
    for (int n = 0; n < 1500; n++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = $urandom;
      bus.out_ready = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
      if ($urandom_range(0, 15) == 0)
        for (int i = 0; i < C; i++) max_thresh[i] = 3'($urandom);
      step();
    end

    // asynchronous reset while a destination is locked
    for (int i = 0; i < C; i++) max_thresh[i] = 3'd1;
    bus.out_ready = 4'b0010;
    bus.in_valid  = 1'b1;
    cyc = 0;
    while (!(m_full && m_locked) && cyc < 20) begin
      bus.in_data = $urandom;
      step();
      cyc++;
    end
    bus.out_ready = 4'b0000;
    step();
    chk("ar_pre_valid", bus.out_valid != 0, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", bus.out_valid, 0);
    chk("ar_in_ready", bus.in_ready, 1);
    chk("ar_out_data", bus.out_data, 0);
    chk("ar_out_dest", bus.out_dest, 0);
    for (int i = 0; i < C; i++) chk("ar_crd", dut.crd_cnt_q[i], 0);
    model_reset();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 4'hF;
    bus.in_valid  = 1'b1;
    run_locks(1, 20);
    chk("ar_first_pick", logged(0), 0);
    bus.in_valid = 1'b0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
